// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : opcodes, ALU encodings, IR field positions and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LOGIC   = 6'b000001;
    localparam logic [5:0] OP_SHIFT   = 6'b000010;
    localparam logic [5:0] OP_ADDI    = 6'b000101;
    localparam logic [5:0] OP_LOAD    = 6'b001101;
    localparam logic [5:0] OP_STORE   = 6'b001110;

    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b000001;
    localparam logic [5:0] FN_AND = 6'b000001;
    localparam logic [5:0] FN_OR  = 6'b000010;
    localparam logic [5:0] FN_SLL = 6'b000011;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_SLL = 2'd3;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int FUNC_HI  = 25;
    localparam int FUNC_LO  = 20;
    localparam int IMM_HI   = 25;
    localparam int IMM_LO   = 10;
    localparam int SHAMT_HI = 19;
    localparam int SHAMT_LO = 15;
    localparam int RD_HI    = 14;
    localparam int RD_LO    = 10;
    localparam int RS_HI    = 9;
    localparam int RS_LO    = 5;
    localparam int RT_HI    = 4;
    localparam int RT_LO    = 0;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_MEM_TO  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic [31:0] sext_imm(input logic [31:0] ir);
        return {{16{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_ctrl_fsm_if : control unit <-> ROM / datapath / start-halt signals
// Rev 1.0
// ----------------------------------------------------------------------------
interface cpu_ctrl_fsm_if #(
    parameter int PC_W = 6
);
    logic            start;
    logic [31:0]     inst;
    logic            mem_ready;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic            ir_we;
    logic            rf_we;
    logic            rf_wsel;
    logic            wb_sel;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic            mem_req;
    logic            mem_we;
    logic            busy;
    logic            halt;
    logic [1:0]      fault;

    modport master (
        input  start, inst, mem_ready,
        output pc, ir, ir_we, rf_we, rf_wsel, wb_sel, alu_src, alu_op,
               mem_req, mem_we, busy, halt, fault
    );

    modport slave (
        output start, inst, mem_ready,
        input  pc, ir, ir_we, rf_we, rf_wsel, wb_sel, alu_src, alu_op,
               mem_req, mem_we, busy, halt, fault
    );
endinterface
`default_nettype wire

// File: rtl/cpu_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_decode : combinational instruction classifier and ALU/WB control decode
// Rev 1.0
// ----------------------------------------------------------------------------
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic        is_nop_o,
    output logic        is_illegal_o,
    output logic        is_rtype_o,
    output logic        is_mem_o,
    output logic        is_store_o,
    output logic [1:0]  alu_op_o,
    output logic        alu_src_o,
    output logic        rf_wsel_o,
    output logic        wb_sel_o
);
    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_unused_fields;

    assign w_op   = ir_i[OP_HI:OP_LO];
    assign w_func = ir_i[FUNC_HI:FUNC_LO];
    // Register and shift fields belong to the datapath, not to control
    assign w_unused_fields = ^{ir_i[SHAMT_HI:SHAMT_LO], ir_i[RD_HI:RD_LO],
                               ir_i[RS_HI:RS_LO], ir_i[RT_HI:RT_LO]};

    always_comb begin
        is_nop_o     = 1'b0;
        is_illegal_o = 1'b0;
        is_rtype_o   = 1'b0;
        is_mem_o     = 1'b0;
        is_store_o   = 1'b0;
        alu_op_o     = ALU_ADD;
        alu_src_o    = 1'b0;
        rf_wsel_o    = 1'b0;
        wb_sel_o     = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                if (w_func == FN_NOP)      is_nop_o     = 1'b1;
                else if (w_func == FN_ADD) is_rtype_o   = 1'b1;
                else                       is_illegal_o = 1'b1;
            end
            OP_LOGIC: begin
                if (w_func == FN_AND) begin
                    is_rtype_o = 1'b1;
                    alu_op_o   = ALU_AND;
                end else if (w_func == FN_OR) begin
                    is_rtype_o = 1'b1;
                    alu_op_o   = ALU_OR;
                end else begin
                    is_illegal_o = 1'b1;
                end
            end
            OP_SHIFT: begin
                if (w_func == FN_SLL) begin
                    is_rtype_o = 1'b1;
                    alu_op_o   = ALU_SLL;
                end else begin
                    is_illegal_o = 1'b1;
                end
            end
            OP_ADDI: begin
                alu_src_o = 1'b1;
                rf_wsel_o = 1'b1;
            end
            OP_LOAD: begin
                is_mem_o  = 1'b1;
                alu_src_o = 1'b1;
                rf_wsel_o = 1'b1;
                wb_sel_o  = 1'b1;
            end
            OP_STORE: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
                alu_src_o  = 1'b1;
            end
            default: is_illegal_o = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_ctrl_fsm : multi-cycle sequencer owning PC, IR, fault and memory timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W        = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_ctrl_fsm_if.master bus
);
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic       w_is_nop, w_is_illegal, w_is_rtype, w_is_mem, w_is_store;
    logic [1:0] w_alu_op;
    logic       w_alu_src, w_rf_wsel, w_wb_sel;
    logic       w_timeout;
    logic       w_ctl_phase;

    cpu_decode u_decode (
        .ir_i         (ir_q),
        .is_nop_o     (w_is_nop),
        .is_illegal_o (w_is_illegal),
        .is_rtype_o   (w_is_rtype),
        .is_mem_o     (w_is_mem),
        .is_store_o   (w_is_store),
        .alu_op_o     (w_alu_op),
        .alu_src_o    (w_alu_src),
        .rf_wsel_o    (w_rf_wsel),
        .wb_sel_o     (w_wb_sel)
    );

    // Fires on the last tolerated idle MEM cycle, so MEM lasts MEM_TIMEOUT cycles
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = (wait_q == CNT_W'(MEM_TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    fault_d = FAULT_NONE;
                end
            end
            S_FETCH: begin
                ir_d    = bus.inst;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_nop) begin
                    state_d = S_FETCH;
                end else if (w_is_illegal) begin
                    state_d = S_HALT;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_d  = '0;
                state_d = (w_is_rtype || !w_is_mem) ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_d = w_is_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_MEM_TO;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // Moore outputs: strobes depend on state_q only
        w_ctl_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        bus.pc      = pc_q;
        bus.ir      = ir_q;
        bus.fault   = fault_q;
        bus.ir_we   = (state_q == S_FETCH);
        bus.rf_we   = (state_q == S_WB);
        bus.mem_req = (state_q == S_MEM);
        bus.mem_we  = (state_q == S_MEM) && w_is_store;
        bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
        bus.halt    = (state_q == S_HALT);
        bus.alu_op  = w_ctl_phase ? w_alu_op  : ALU_ADD;
        bus.alu_src = w_ctl_phase ? w_alu_src : 1'b0;
        bus.rf_wsel = w_ctl_phase ? w_rf_wsel : 1'b0;
        bus.wb_sel  = w_ctl_phase ? w_wb_sel  : 1'b0;
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu_ctrl_fsm : directed scenarios plus random programs vs. reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;
    localparam int PC_W        = 6;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [31:0] W_ADD   = 32'h0010_0443;
    localparam logic [31:0] W_ADDI  = 32'h1400_2828;
    localparam logic [31:0] W_LOAD  = 32'h37FF_D501;
    localparam logic [31:0] W_STORE = 32'h3800_1402;
    localparam logic [31:0] W_ILL   = 32'hFC00_0000;

    // {ir_we, rf_we, mem_req, mem_we, busy, halt, fault[1:0]}
    localparam logic [7:0] V_IDLE  = 8'h00;
    localparam logic [7:0] V_FETCH = 8'h88;
    localparam logic [7:0] V_BUSY  = 8'h08;
    localparam logic [7:0] V_LD    = 8'h28;
    localparam logic [7:0] V_ST    = 8'h38;
    localparam logic [7:0] V_WB    = 8'h48;
    localparam logic [7:0] V_HALT  = 8'h04;

    localparam int K_NOP = 0, K_R = 1, K_ADDI = 2, K_LD = 3, K_ST = 4, K_ILL = 5;

    typedef struct packed {
        logic [7:0]  strb;
        logic [5:0]  pc;
        logic [31:0] ir;
        logic [2:0]  alu;
        logic [1:0]  wbc;
        logic        chk_a;
        logic        chk_w;
        logic        st;
        logic        mr;
    } cyc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if #(.PC_W(PC_W)) bus_if ();
    logic [31:0] rom [64];
    assign bus_if.inst = rom[bus_if.pc];

    cpu_ctrl_fsm #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    cyc_t exp_q [$];

    function automatic logic [7:0] strobes();
        return {bus_if.ir_we, bus_if.rf_we, bus_if.mem_req, bus_if.mem_we & bus_if.mem_req,
                bus_if.busy, bus_if.halt, bus_if.fault};
    endfunction

    function automatic logic [2:0] alu_ctl();
        return {bus_if.alu_op, bus_if.alu_src};
    endfunction

    function automatic logic [1:0] wb_ctl();
        return {bus_if.rf_wsel, bus_if.wb_sel};
    endfunction

    function automatic int kind_of(input logic [31:0] w);
        case (w[31:26])
            6'd5:  return K_ADDI;
            6'd13: return K_LD;
            6'd14: return K_ST;
            default: ;
        endcase
        case (w[31:20])
            12'h000:                   return K_NOP;
            12'h001, 12'h041, 12'h042, 12'h083: return K_R;
            default:                   return K_ILL;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [31:0] w);
        case (w[31:20])
            12'h041: return 2'd1;
            12'h042: return 2'd2;
            12'h083: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic tick(input logic st, input logic mr);
        bus_if.start     = st;
        bus_if.mem_ready = mr;
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_rom(input logic [31:0] w);
        for (int i = 0; i < 64; i++) rom[i] = w;
    endtask

    task automatic test_reset();
        fill_rom(32'h0);
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()});
        end
        do_reset();
    endtask

    task automatic test_add();
        fill_rom(32'h0);
        rom[1] = W_ADD;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_FETCH, 6'd1}) begin
            n_fail++; $display("FAIL add_fetch: got %h want %h", {strobes(), bus_if.pc}, {V_FETCH, 6'd1});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if (bus_if.ir !== W_ADD) begin
            n_fail++; $display("FAIL add_ir: got %h want %h", bus_if.ir, W_ADD);
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), alu_ctl()} !== {V_BUSY, 3'b000}) begin
            n_fail++; $display("FAIL add_exec: got %h want %h", {strobes(), alu_ctl()}, {V_BUSY, 3'b000});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), alu_ctl(), wb_ctl()} !== {V_WB, 3'b000, 2'b00}) begin
            n_fail++; $display("FAIL add_wb: got %h want %h", {strobes(), alu_ctl(), wb_ctl()}, {V_WB, 5'b0});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_FETCH, 6'd2}) begin
            n_fail++; $display("FAIL add_next_fetch: got %h want %h", {strobes(), bus_if.pc}, {V_FETCH, 6'd2});
        end
    endtask

    task automatic test_addi();
        fill_rom(32'h0);
        rom[0] = W_ADDI;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        n_cmp++;
        if ({strobes(), alu_ctl()} !== {V_BUSY, 3'b001}) begin
            n_fail++; $display("FAIL addi_exec: got %h want %h", {strobes(), alu_ctl()}, {V_BUSY, 3'b001});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), alu_ctl(), wb_ctl()} !== {V_WB, 3'b001, 2'b10}) begin
            n_fail++; $display("FAIL addi_wb: got %h want %h", {strobes(), alu_ctl(), wb_ctl()}, {V_WB, 3'b001, 2'b10});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_FETCH, 6'd1}) begin
            n_fail++; $display("FAIL addi_4cyc: got %h want %h", {strobes(), bus_if.pc}, {V_FETCH, 6'd1});
        end
    endtask

    task automatic test_load_wait();
        fill_rom(32'h0);
        rom[0] = W_LOAD;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({strobes(), alu_ctl(), bus_if.ir} !== {V_LD, 3'b001, W_LOAD}) begin
                n_fail++; $display("FAIL load_mem%0d: got %h want %h", i, {strobes(), alu_ctl(), bus_if.ir}, {V_LD, 3'b001, W_LOAD});
            end
            tick(1'b0, i == 3);
        end
        n_cmp++;
        if ({strobes(), wb_ctl()} !== {V_WB, 2'b11}) begin
            n_fail++; $display("FAIL load_wb: got %h want %h", {strobes(), wb_ctl()}, {V_WB, 2'b11});
        end
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_FETCH, 6'd1}) begin
            n_fail++; $display("FAIL load_8cyc: got %h want %h", {strobes(), bus_if.pc}, {V_FETCH, 6'd1});
        end
    endtask

    task automatic test_store_timeout();
        fill_rom(32'h0);
        rom[0] = W_STORE;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            n_cmp++;
            if (strobes() !== V_ST) begin
                n_fail++; $display("FAIL store_wait%0d: got %h want %h", i, strobes(), V_ST);
            end
            tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (strobes() !== (V_HALT | 8'h02)) begin
                n_fail++; $display("FAIL store_timeout_halt%0d: got %h want %h", i, strobes(), V_HALT | 8'h02);
            end
            tick(i == 1, 1'b0);
        end
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_FETCH, 6'd0}) begin
            n_fail++; $display("FAIL store_restart: got %h want %h", {strobes(), bus_if.pc}, {V_FETCH, 6'd0});
        end
    endtask

    task automatic test_illegal();
        fill_rom(32'h0);
        rom[0] = W_ILL;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        n_cmp++;
        if (strobes() !== V_BUSY) begin
            n_fail++; $display("FAIL illegal_decode: got %h want %h", strobes(), V_BUSY);
        end
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (strobes() !== (V_HALT | 8'h01)) begin
                n_fail++; $display("FAIL illegal_halt%0d: got %h want %h", i, strobes(), V_HALT | 8'h01);
            end
            tick(1'b0, 1'b1);
        end
    endtask

    task automatic test_nop_wrap();
        fill_rom(32'h0);
        do_reset();
        tick(1'b1, 1'b0);
        for (int c = 0; c < 130; c++) begin
            logic [7:0] ev;
            logic [5:0] ep;
            ev = (c % 2 == 0) ? V_FETCH : V_BUSY;
            ep = 6'(((c / 2) + (c % 2)) % 64);
            n_cmp++;
            if ({strobes(), bus_if.pc} !== {ev, ep}) begin
                n_fail++; $display("FAIL nop_wrap c%0d: got %h want %h", c, {strobes(), bus_if.pc}, {ev, ep});
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        fill_rom(32'h0);
        rom[0] = W_LOAD;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        n_cmp++;
        if ({strobes(), bus_if.pc} !== {V_LD, 6'd1}) begin
            n_fail++; $display("FAIL busy_start_ignored: got %h want %h", {strobes(), bus_if.pc}, {V_LD, 6'd1});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()} !== '0) begin
            n_fail++; $display("FAIL reset_mid_mem: got %h want 0", {strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        rom[0] = W_ADD;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        n_cmp++;
        if (strobes() !== V_WB) begin
            n_fail++; $display("FAIL wb_before_reset: got %h want %h", strobes(), V_WB);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()} !== '0) begin
            n_fail++; $display("FAIL reset_mid_wb: got %h want 0", {strobes(), bus_if.pc, bus_if.ir, alu_ctl(), wb_ctl()});
        end
        @(negedge clk);
        n_cmp++;
        if (strobes() !== V_IDLE) begin
            n_fail++; $display("FAIL reset_held: got %h want %h", strobes(), V_IDLE);
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 15))
            0, 1:    w = 32'h0;
            2:       w = {6'd0, 6'd1, 20'($urandom)};
            3:       w = {6'd1, 6'd1, 20'($urandom)};
            4:       w = {6'd1, 6'd2, 20'($urandom)};
            5:       w = {6'd2, 6'd3, 20'($urandom)};
            6, 7:    w = {6'd5, 26'($urandom)};
            8, 9, 10: w = {6'd13, 26'($urandom)};
            11, 12, 13: w = {6'd14, 26'($urandom)};
            14:      w = {6'd0, 6'd0, 20'($urandom)};
            default: begin
                w = $urandom;
                while (kind_of(w) != K_ILL) w = $urandom;
            end
        endcase
        return w;
    endfunction

    task automatic push(input logic [7:0] s, input int p, input logic [31:0] irm,
                        input logic [2:0] a, input logic [1:0] wc, input logic ca,
                        input logic cw, input logic st, input logic mr);
        cyc_t c;
        c.strb = s; c.pc = 6'(p); c.ir = irm; c.alu = a; c.wbc = wc;
        c.chk_a = ca; c.chk_w = cw; c.st = st; c.mr = mr;
        exp_q.push_back(c);
    endtask

    task automatic build_model(input int ncyc);
        int          p;
        int          k;
        int          w;
        int          h;
        logic [31:0] irm;
        logic [31:0] word;
        logic [1:0]  flt;
        logic [2:0]  a;
        p = 0; irm = 32'h0; flt = 2'd0;
        exp_q.delete();
        push(V_IDLE, 0, irm, 3'b0, 2'b0, 1'b0, 1'b0, 1'b1, 1'($urandom));
        while (exp_q.size() < ncyc) begin
            word = rom[p];
            push(V_FETCH, p, irm, 3'b0, 2'b0, 1'b0, 1'b0, $urandom_range(0, 5) == 0, 1'($urandom));
            irm = word;
            p = (p + 1) % 64;
            push(V_BUSY, p, irm, 3'b0, 2'b0, 1'b0, 1'b0, $urandom_range(0, 5) == 0, 1'($urandom));
            k = kind_of(word);
            a = {alu_of(word), k != K_R};
            if (k == K_NOP) continue;
            if (k == K_ILL) begin
                flt = 2'd1;
            end else begin
                push(V_BUSY, p, irm, a, 2'b0, 1'b1, 1'b0, $urandom_range(0, 5) == 0, 1'($urandom));
                if (k == K_LD || k == K_ST) begin
                    w = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT + $urandom_range(0, 5) : $urandom_range(0, 4);
                    for (int i = 0; i < w && i < MEM_TIMEOUT; i++)
                        push((k == K_ST) ? V_ST : V_LD, p, irm, a, 2'b0, 1'b1, 1'b0, $urandom_range(0, 5) == 0, 1'b0);
                    if (w >= MEM_TIMEOUT) flt = 2'd2;
                    else push((k == K_ST) ? V_ST : V_LD, p, irm, a, 2'b0, 1'b1, 1'b0, $urandom_range(0, 5) == 0, 1'b1);
                end
                if (flt == 2'd0 && k != K_ST)
                    push(V_WB, p, irm, a, {k == K_ADDI || k == K_LD, k == K_LD}, 1'b1, 1'b1,
                         $urandom_range(0, 5) == 0, 1'($urandom));
            end
            if (flt != 2'd0) begin
                h = $urandom_range(1, 3);
                for (int i = 0; i < h; i++)
                    push(V_HALT | {6'b0, flt}, p, irm, 3'b0, 2'b0, 1'b0, 1'b0, i == h - 1, 1'($urandom));
                flt = 2'd0;
                p = 0;
            end
        end
    endtask

    task automatic test_random();
        cyc_t e;
        int   run_fail;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) rom[i] = rand_word();
            build_model(300);
            do_reset();
            run_fail = 0;
            while (exp_q.size() > 0 && run_fail == 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({strobes(), bus_if.pc, bus_if.ir} !== {e.strb, e.pc, e.ir}) begin
                    n_fail++; run_fail++;
                    $display("FAIL random r%0d state: got %h want %h", r, {strobes(), bus_if.pc, bus_if.ir}, {e.strb, e.pc, e.ir});
                end
                if (e.chk_a) begin
                    n_cmp++;
                    if (alu_ctl() !== e.alu) begin
                        n_fail++; run_fail++;
                        $display("FAIL random r%0d alu: got %h want %h", r, alu_ctl(), e.alu);
                    end
                end
                if (e.chk_w) begin
                    n_cmp++;
                    if (wb_ctl() !== e.wbc) begin
                        n_fail++; run_fail++;
                        $display("FAIL random r%0d wb: got %h want %h", r, wb_ctl(), e.wbc);
                    end
                end
                tick(e.st, e.mr);
            end
        end
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_addi();
        test_load_wait();
        test_store_timeout();
        test_illegal();
        test_nop_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
